// File: rtl/spart_echo_ctrl.sv
// Bus-side sequencer for the SPART: programs the baud divisor, then echoes received
// bytes back to the transmitter through a small FIFO, one registered bus op at a time.
module spart_echo_ctrl #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DIV_4800  = 650,
    parameter int unsigned DIV_9600  = 325,
    parameter int unsigned DIV_19200 = 162,
    parameter int unsigned DIV_38400 = 80
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               br_cfg,
    input  logic                     rda,
    input  logic                     tbr,
    input  logic [7:0]               dbus_in,
    output logic                     iocs,
    output logic                     iorw,
    output logic [1:0]               ioaddr,
    output logic [7:0]               dbus_out,
    output logic                     dbus_oe,
    output logic                     cfg_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_CFG_LO, S_GAP0, S_CFG_HI, S_GAP, S_IDLE, S_RD, S_WR
    } state_t;

    typedef enum logic { RR_READ, RR_WRITE } rr_t;

    state_t          state_q, state_d;
    rr_t             rr_q, rr_d;
    logic [1:0]      br_q, br_d;
    logic            cfg_done_q, cfg_done_d;
    logic            iocs_q, iocs_d;
    logic            iorw_q, iorw_d;
    logic [1:0]      ioaddr_q, ioaddr_d;
    logic [7:0]      dbus_out_q, dbus_out_d;
    logic            dbus_oe_q, dbus_oe_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [15:0]     div;
    logic            push, pop, rd_ok, wr_ok;

    always_comb begin
        unique case (br_q)
            2'b00:   div = 16'(DIV_4800);
            2'b01:   div = 16'(DIV_9600);
            2'b10:   div = 16'(DIV_19200);
            default: div = 16'(DIV_38400);
        endcase
    end

    // Outputs lag the state by one edge, so a RD/WR strobe is on the bus while
    // the state is already GAP; FIFO push/pop therefore keys off the strobe itself.
    assign push  = iocs_q &  iorw_q & (ioaddr_q == 2'b00);
    assign pop   = iocs_q & ~iorw_q & (ioaddr_q == 2'b00);
    assign rd_ok = rda & (count_q < FULL);
    assign wr_ok = tbr & (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CFG_LO;
            rr_q       <= RR_READ;
            br_q       <= br_cfg;
            cfg_done_q <= 1'b0;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= 2'b00;
            dbus_out_q <= '0;
            dbus_oe_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            br_q       <= br_d;
            cfg_done_q <= cfg_done_d;
            iocs_q     <= iocs_d;
            iorw_q     <= iorw_d;
            ioaddr_q   <= ioaddr_d;
            dbus_out_q <= dbus_out_d;
            dbus_oe_q  <= dbus_oe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        br_d       = br_q;
        cfg_done_d = cfg_done_q;
        case (state_q)
            S_CFG_LO: state_d = S_GAP0;
            S_GAP0:   state_d = S_CFG_HI;
            S_CFG_HI: begin
                state_d    = S_GAP;
                cfg_done_d = 1'b1;
            end
            S_GAP:    state_d = S_IDLE;
            S_RD:     state_d = S_GAP;
            S_WR:     state_d = S_GAP;
            S_IDLE: begin
                if (br_cfg != br_q) begin
                    br_d       = br_cfg;
                    cfg_done_d = 1'b0;
                    state_d    = S_CFG_LO;
                end else if (rd_ok && wr_ok) begin
                    state_d = (rr_q == RR_READ) ? S_RD : S_WR;
                    rr_d    = (rr_q == RR_READ) ? RR_WRITE : RR_READ;
                end else if (rd_ok) begin
                    state_d = S_RD;
                end else if (wr_ok) begin
                    state_d = S_WR;
                end
            end
            default:  state_d = S_CFG_LO;
        endcase
    end

    always_comb begin
        iocs_d     = 1'b0;
        iorw_d     = 1'b1;
        ioaddr_d   = ioaddr_q;
        dbus_out_d = dbus_out_q;
        dbus_oe_d  = 1'b0;
        case (state_q)
            S_CFG_LO: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = 2'b10;
                dbus_out_d = div[7:0];
                dbus_oe_d  = 1'b1;
            end
            S_CFG_HI: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = 2'b11;
                dbus_out_d = div[15:8];
                dbus_oe_d  = 1'b1;
            end
            S_RD: begin
                iocs_d   = 1'b1;
                ioaddr_d = 2'b00;
            end
            S_WR: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = 2'b00;
                dbus_out_d = mem_q[rd_ptr_q];
                dbus_oe_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = dbus_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            count_d         = count_q + CW'(1);
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
        end
    end

    assign iocs       = iocs_q;
    assign iorw       = iorw_q;
    assign ioaddr     = ioaddr_q;
    assign dbus_out   = dbus_out_q;
    assign dbus_oe    = dbus_oe_q;
    assign cfg_done   = cfg_done_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// Bench for spart_echo_ctrl: a behavioural SPART receive side feeds bytes, a bus
// logger records every strobe, and an expected-byte queue checks the echo order.
module tb_spart_echo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda, tbr;
    logic [7:0] dbus_in, dbus_out;
    logic       iocs, iorw, dbus_oe, cfg_done;
    logic [1:0] ioaddr;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    spart_echo_ctrl #(
        .DEPTH(4), .DIV_4800(650), .DIV_9600(325), .DIV_19200(162), .DIV_38400(80)
    ) dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr), .dbus_in(dbus_in),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .dbus_out(dbus_out), .dbus_oe(dbus_oe),
        .cfg_done(cfg_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPART receive side: bytes are pending until a read strobe consumes one.
    logic [7:0] rx_buf [0:31];
    int rx_wr = 0;
    int rx_rd = 0;
    assign rda     = (rx_wr != rx_rd);
    assign dbus_in = rx_buf[rx_rd[4:0]];
    always @(posedge clk)
        if (iocs && iorw && ioaddr == 2'b00 && rx_rd != rx_wr) rx_rd <= rx_rd + 1;

    logic       log_rw   [0:255];
    logic [1:0] log_addr [0:255];
    logic [7:0] log_dout [0:255];
    logic       log_oe   [0:255];
    logic       log_cd   [0:255];
    logic [2:0] log_cnt  [0:255];
    int         log_c    [0:255];
    int         op_n = 0;
    always @(negedge clk)
        if (iocs && op_n < 256) begin
            log_rw[op_n]   <= iorw;
            log_addr[op_n] <= ioaddr;
            log_dout[op_n] <= dbus_out;
            log_oe[op_n]   <= dbus_oe;
            log_cd[op_n]   <= cfg_done;
            log_cnt[op_n]  <= fifo_count;
            log_c[op_n]    <= cyc;
            op_n           <= op_n + 1;
        end

    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    int c_rst;
    int nx;

    task automatic push_byte(input logic [7:0] b);
        rx_buf[rx_wr[4:0]] = b;
        rx_wr = rx_wr + 1;
        exp_q.push_back(b);
    endtask

    task automatic test_reset;
        rst = 1'b1; br_cfg = 2'b01; tbr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (iocs !== 1'b0) begin failures++; $display("FAIL rst_iocs got=%b exp=0", iocs); end
        checks++; if (iorw !== 1'b1) begin failures++; $display("FAIL rst_iorw got=%b exp=1", iorw); end
        checks++; if (ioaddr !== 2'b00) begin failures++; $display("FAIL rst_ioaddr got=%b exp=00", ioaddr); end
        checks++; if (dbus_out !== 8'h00) begin failures++; $display("FAIL rst_dbus_out got=%h exp=00", dbus_out); end
        checks++; if (dbus_oe !== 1'b0) begin failures++; $display("FAIL rst_dbus_oe got=%b exp=0", dbus_oe); end
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL rst_cfg_done got=%b exp=0", cfg_done); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        c_rst = cyc;
        rst = 1'b0;
    endtask

    task automatic test_config;
        for (int i = 0; i < 20 && op_n < 2; i++) begin @(negedge clk); #1; end
        checks++; if (op_n < 2) begin failures++; $display("FAIL cfg_timeout ops=%0d exp=2", op_n); end
        checks++; if ({log_rw[0], log_addr[0], log_oe[0]} !== 4'b0101) begin
            failures++; $display("FAIL cfg_lo_ctrl got rw=%b addr=%b oe=%b exp rw=0 addr=10 oe=1", log_rw[0], log_addr[0], log_oe[0]); end
        checks++; if (log_dout[0] !== 8'h45) begin failures++; $display("FAIL cfg_lo_data got=%h exp=45", log_dout[0]); end
        checks++; if (log_c[0] !== c_rst + 1) begin failures++; $display("FAIL cfg_lo_cycle got=%0d exp=%0d", log_c[0], c_rst + 1); end
        checks++; if ({log_rw[1], log_addr[1], log_oe[1]} !== 4'b0111) begin
            failures++; $display("FAIL cfg_hi_ctrl got rw=%b addr=%b oe=%b exp rw=0 addr=11 oe=1", log_rw[1], log_addr[1], log_oe[1]); end
        checks++; if (log_dout[1] !== 8'h01) begin failures++; $display("FAIL cfg_hi_data got=%h exp=01", log_dout[1]); end
        checks++; if (log_c[1] !== c_rst + 3) begin failures++; $display("FAIL cfg_hi_cycle got=%0d exp=%0d", log_c[1], c_rst + 3); end
        checks++; if (log_cd[0] !== 1'b0 || log_cd[1] !== 1'b1) begin
            failures++; $display("FAIL cfg_done_edge got lo=%b hi=%b exp lo=0 hi=1", log_cd[0], log_cd[1]); end
        checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL cfg_done got=%b exp=1", cfg_done); end
    endtask

    task automatic test_echo;
        int n0;
        n0 = op_n;
        tbr = 1'b1;
        push_byte(8'h41);
        for (int i = 0; i < 30 && op_n < n0 + 2; i++) begin @(negedge clk); #1; end
        checks++; if (op_n < n0 + 2) begin failures++; $display("FAIL echo_timeout ops=%0d exp=%0d", op_n - n0, 2); end
        checks++; if ({log_rw[n0], log_addr[n0], log_oe[n0]} !== 4'b1000) begin
            failures++; $display("FAIL echo_rd_ctrl got rw=%b addr=%b oe=%b exp rw=1 addr=00 oe=0", log_rw[n0], log_addr[n0], log_oe[n0]); end
        checks++; if ({log_rw[n0+1], log_addr[n0+1], log_oe[n0+1]} !== 4'b0001) begin
            failures++; $display("FAIL echo_wr_ctrl got rw=%b addr=%b oe=%b exp rw=0 addr=00 oe=1", log_rw[n0+1], log_addr[n0+1], log_oe[n0+1]); end
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (log_dout[n0+1] !== exp_b) begin failures++; $display("FAIL echo_data got=%h exp=%h", log_dout[n0+1], exp_b); end
        checks++; if (log_cnt[n0+1] !== 3'd1) begin failures++; $display("FAIL echo_count_at_wr got=%0d exp=1", log_cnt[n0+1]); end
        checks++; if (log_c[n0+1] - log_c[n0] < 2) begin failures++; $display("FAIL echo_gap got=%0d exp>=2", log_c[n0+1] - log_c[n0]); end
        repeat (3) @(negedge clk); #1;
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL echo_count_end got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_full;
        int n0;
        tbr = 1'b0;
        n0 = op_n;
        for (int b = 0; b < 5; b++) push_byte(8'h10 + 8'(b));
        repeat (40) @(negedge clk); #1;
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
        checks++; if (op_n - n0 !== 4) begin failures++; $display("FAIL full_reads got=%0d exp=4", op_n - n0); end
        checks++; if (rda !== 1'b1) begin failures++; $display("FAIL full_fifth_held got rda=%b exp=1", rda); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (log_rw[n0+i] !== 1'b1) begin failures++; $display("FAIL full_op_kind op%0d got rw=%b exp=1", i, log_rw[n0+i]); end
        end
        nx = op_n;
        tbr = 1'b1;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            @(negedge clk); #1;
            while (nx < op_n) begin
                if (log_rw[nx] == 1'b0 && log_addr[nx] == 2'b00) begin
                    exp_b = exp_q.pop_front();
                    checks++; if (log_dout[nx] !== exp_b) begin failures++; $display("FAIL full_order op%0d got=%h exp=%h", nx, log_dout[nx], exp_b); end
                end
                nx++;
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_drain_timeout left=%0d exp=0", exp_q.size()); end
        repeat (3) @(negedge clk); #1;
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL full_count_end got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_back_to_back;
        int n0;
        tbr = 1'b0;
        push_byte(8'h60); push_byte(8'h61);
        for (int i = 0; i < 40 && fifo_count != 3'd2; i++) begin @(negedge clk); #1; end
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL b2b_preload got=%0d exp=2", fifo_count); end
        n0 = op_n;
        nx = n0;
        for (int b = 0; b < 6; b++) push_byte(8'h62 + 8'(b));
        tbr = 1'b1;
        for (int i = 0; i < 80 && op_n < n0 + 8; i++) begin @(negedge clk); #1; end
        checks++; if (op_n < n0 + 8) begin failures++; $display("FAIL b2b_timeout ops=%0d exp=8", op_n - n0); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (log_rw[n0+i] === log_rw[n0+i-1]) begin failures++; $display("FAIL b2b_alternate op%0d got rw=%b same as previous", i, log_rw[n0+i]); end
            checks++; if (log_c[n0+i] - log_c[n0+i-1] < 2) begin failures++; $display("FAIL b2b_gap op%0d got=%0d exp>=2", i, log_c[n0+i] - log_c[n0+i-1]); end
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (log_cnt[n0+i] < 3'd1 || log_cnt[n0+i] > 3'd3) begin failures++; $display("FAIL b2b_count op%0d got=%0d exp=1..3", i, log_cnt[n0+i]); end
        end
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            while (nx < op_n) begin
                if (log_rw[nx] == 1'b0 && log_addr[nx] == 2'b00) begin
                    exp_b = exp_q.pop_front();
                    checks++; if (log_dout[nx] !== exp_b) begin failures++; $display("FAIL b2b_order op%0d got=%h exp=%h", nx, log_dout[nx], exp_b); end
                end
                nx++;
            end
            @(negedge clk); #1;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain_timeout left=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_baud_change;
        int n0;
        tbr = 1'b0;
        repeat (5) @(negedge clk); #1;
        push_byte(8'h71); push_byte(8'h72);
        for (int i = 0; i < 40 && fifo_count != 3'd2; i++) begin @(negedge clk); #1; end
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL baud_preload got=%0d exp=2", fifo_count); end
        n0 = op_n;
        br_cfg = 2'b11;
        for (int i = 0; i < 30 && op_n < n0 + 2; i++) begin @(negedge clk); #1; end
        checks++; if (op_n < n0 + 2) begin failures++; $display("FAIL baud_timeout ops=%0d exp=2", op_n - n0); end
        checks++; if ({log_rw[n0], log_addr[n0], log_dout[n0]} !== {1'b0, 2'b10, 8'h50}) begin
            failures++; $display("FAIL baud_lo got rw=%b addr=%b data=%h exp rw=0 addr=10 data=50", log_rw[n0], log_addr[n0], log_dout[n0]); end
        checks++; if ({log_rw[n0+1], log_addr[n0+1], log_dout[n0+1]} !== {1'b0, 2'b11, 8'h00}) begin
            failures++; $display("FAIL baud_hi got rw=%b addr=%b data=%h exp rw=0 addr=11 data=00", log_rw[n0+1], log_addr[n0+1], log_dout[n0+1]); end
        checks++; if (log_cd[n0] !== 1'b0 || log_cd[n0+1] !== 1'b1) begin
            failures++; $display("FAIL baud_cfg_done got lo=%b hi=%b exp lo=0 hi=1", log_cd[n0], log_cd[n0+1]); end
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL baud_fifo_kept got=%0d exp=2", fifo_count); end
        nx = op_n;
        tbr = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(negedge clk); #1;
            while (nx < op_n) begin
                if (log_rw[nx] == 1'b0 && log_addr[nx] == 2'b00) begin
                    exp_b = exp_q.pop_front();
                    checks++; if (log_dout[nx] !== exp_b) begin failures++; $display("FAIL baud_order op%0d got=%h exp=%h", nx, log_dout[nx], exp_b); end
                end
                nx++;
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL baud_drain_timeout left=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int n0;
        logic found;
        tbr = 1'b0;
        repeat (5) @(negedge clk); #1;
        for (int b = 0; b < 4; b++) push_byte(8'h80 + 8'(b));
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk); #1;
            found = iocs && iorw && ioaddr == 2'b00 && fifo_count == 3'd3;
        end
        checks++; if (!found) begin failures++; $display("FAIL rmid_no_rd_at_3 got=0 exp=1"); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({iocs, iorw, ioaddr, dbus_oe} !== 5'b01000) begin
            failures++; $display("FAIL rmid_ctrl got iocs=%b iorw=%b addr=%b oe=%b exp 0 1 00 0", iocs, iorw, ioaddr, dbus_oe); end
        checks++; if (dbus_out !== 8'h00) begin failures++; $display("FAIL rmid_dbus_out got=%h exp=00", dbus_out); end
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL rmid_cfg_done got=%b exp=0", cfg_done); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", fifo_count); end
        exp_q.delete();
        c_rst = cyc;
        n0 = op_n;
        rst = 1'b0;
        for (int i = 0; i < 10 && op_n < n0 + 1; i++) begin @(negedge clk); #1; end
        checks++; if ({log_rw[n0], log_addr[n0], log_dout[n0]} !== {1'b0, 2'b10, 8'h50} || log_c[n0] !== c_rst + 1) begin
            failures++; $display("FAIL rmid_restart got rw=%b addr=%b data=%h cyc=%0d exp rw=0 addr=10 data=50 cyc=%0d",
                                 log_rw[n0], log_addr[n0], log_dout[n0], log_c[n0], c_rst + 1); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_echo();
        test_full();
        test_back_to_back();
        test_baud_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
